line_draw_engine: RTL and testbench
===================================

Name: line_draw_engine

Overview:
Bresenham line rasteriser that sits directly upstream of the double-buffer subsystem. It accepts line commands (two endpoints plus a 1-bit colour) and emits one pixel write per clock as a linear frame-buffer address, a data bit and a write enable. Writes are issued only while the system controller grants the drawing window via str_line_drawing. The frame-buffer mux and arbiter consume these writes.

Parameters:
H_RES, 640, horizontal resolution in pixels; address = y*H_RES + x
V_RES, 480, vertical resolution in lines
COORD_W, 10, width of each x/y coordinate
ADDR_W, 19, width of the linear pixel address

Ports:
clk  input  1  system clock, all logic rising-edge
reset  input  1  asynchronous, active-high reset
str_line_drawing  input  1  level enable from system controller; drawing window open while high
cmd_valid  input  1  line command present
cmd_ready  output  1  engine can accept a command this cycle
x0  input  COORD_W  start x
y0  input  COORD_W  start y
x1  input  COORD_W  end x
y1  input  COORD_W  end y
color  input  1  pixel value for the whole line
line_drawing_addr_1  output  ADDR_W  pixel write address
line_drawing_data  output  1  pixel write data
we_line_drawin  output  1  pixel write enable, one pixel per asserted cycle
busy  output  1  high from command accept until done
done  output  1  one-cycle pulse after the last pixel of a line

Behaviour:
- Reset (async, active-high): FSM to IDLE. line_drawing_addr_1=0, line_drawing_data=0, we_line_drawin=0, busy=0, done=0. cmd_ready=0 during reset.
- cmd_ready = (state==IDLE) & str_line_drawing. A command is accepted on a cycle where cmd_valid & cmd_ready; x0..y1 and color are registered then.
- FSM states: IDLE, SETUP, PLOT, DONE.
- IDLE -> SETUP on accept.
- SETUP (1 cycle): compute dx=|x1-x0|, dy=-|y1-y0|, sx=+1/-1, sy=+1/-1, err=dx+dy. err, dx and dy are signed COORD_W+2 bits. Current point (x,y)=(x0,y0).
- PLOT: each cycle, emit the current point. Registered outputs appear on the next cycle.
  - If (x,y)==(x1,y1), go to DONE.
  - Otherwise, with e2=2*err:
    - if e2>=dy: err+=dy, x+=sx
    - if e2<=dx: err+=dx, y+=sy
    - Both updates use the old err and can apply in the same cycle.
- DONE (1 cycle): done=1, then to IDLE.
- busy=1 in SETUP, PLOT and DONE.
- Address = y*H_RES + x, computed by shift-add (y<<9 + y<<7 + x for the default). Registered together with we and data.
- Latency:
  - accept at cycle T; SETUP at T+1; first write visible at T+3.
  - N = max(dx,|dy|)+1 writes occur on consecutive cycles.
  - done is high in the cycle after the last write (we low).
  - cmd_ready returns 1 the cycle after done.
- Clipping: a point with x>=H_RES or y>=V_RES still steps but suppresses we for that cycle. Address is don't-care when we=0.
- Window loss: if str_line_drawing falls during SETUP or PLOT, the line is aborted. we deasserts from the next cycle, and the FSM goes to IDLE without a done pulse.
- Reset mid-line: immediate return to reset values; no residual write.
- Degenerate line (x0==x1 and y0==y1): exactly one write, then done.
- we_line_drawin is never high outside PLOT-driven output cycles.

Test Plan:
- Horizontal line (0,0)->(3,0), color=1: addresses 0,1,2,3 on 4 consecutive cycles with data=1. First write 3 cycles after accept; done the next cycle.
- Single point (639,479): exactly one write at address 307199, then done; cmd_ready=0 throughout, back to 1 after done.
- Diagonal (10,10)->(12,12): writes at 6410, 7051, 7692.
- Steep negative line (5,4)->(4,0): writes at 2565, 1925, 1284, 644, 4, in that order.
- Clip line (638,0)->(641,0): writes only at 638 and 639. The two clipped cycles have we=0; done still arrives after 4 plot cycles.
- Abort and reset cases:
  - Drop str_line_drawing after the 2nd write of (0,0)->(9,0): no further writes, no done, returns to IDLE.
  - Assert reset mid-line: all outputs 0 immediately.
  - After reset: a new command with enable high is accepted normally.

Source files
------------

// File: rtl/line_draw_engine.sv
// -----------------------------------------------------------------------------
// line_draw_engine
//
// Bresenham line rasteriser feeding the double-buffer subsystem. A line command
// carries two endpoints and a 1-bit colour. The engine issues at most one pixel
// write per clock as a linear frame-buffer address (y*H_RES + x), a data bit and
// a write enable. Writes are issued only while str_line_drawing is high.
//
// Ports:
//   clk                 system clock, rising edge
//   reset               asynchronous, active-high reset
//   str_line_drawing    drawing window open while high; a fall aborts a line
//   cmd_valid/cmd_ready command handshake. A command transfers on any rising
//                       edge where both are high; cmd_ready only depends on the
//                       engine state and the window, never on cmd_valid
//   x0,y0,x1,y1,color   line endpoints and pixel value, captured on transfer
//   line_drawing_addr_1 pixel write address (registered)
//   line_drawing_data   pixel write data (registered)
//   we_line_drawin      pixel write enable, one pixel per asserted cycle
//   busy                high while a line is being set up, plotted or finished
//   done                one-cycle pulse the cycle after the last write
//   dbg_state           current FSM state, for observation only
// -----------------------------------------------------------------------------
module line_draw_engine #(
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int COORD_W = 10,
    parameter int ADDR_W  = 19
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               str_line_drawing,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic               color,
    output logic [ADDR_W-1:0]  line_drawing_addr_1,
    output logic               line_drawing_data,
    output logic               we_line_drawin,
    output logic               busy,
    output logic               done,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PLOT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // err/dx/dy width; e2 needs one more bit to hold 2*err.
    localparam int EW = COORD_W + 2;

    localparam logic [COORD_W:0]  H_LIM  = (COORD_W+1)'(H_RES);
    localparam logic [COORD_W:0]  V_LIM  = (COORD_W+1)'(V_RES);
    localparam logic [ADDR_W-1:0] H_BITS = ADDR_W'(H_RES);
    localparam logic signed [EW-1:0] ZERO_E = '0;

    state_t                 state_q;
    logic [COORD_W-1:0]     x_q, y_q, x1_q, y1_q;
    logic [COORD_W-1:0]     x_d, y_d;
    logic                   color_q;
    logic signed [EW-1:0]   dx_q, dy_q, err_q;
    logic signed [EW-1:0]   err_d;
    logic                   sx_neg_q, sy_neg_q;
    logic [ADDR_W-1:0]      addr_q;
    logic                   data_q, we_q, done_q;

    // Setup-time magnitudes (x_q/y_q hold the start point during SETUP).
    logic signed [EW-1:0]   adx, ady;
    logic signed [EW:0]     e2, dx_e, dy_e;
    logic                   step_x, step_y, at_end, in_range;
    logic [ADDR_W-1:0]      pix_addr_d;

    // y*H_RES + x as a sum of shifted copies of y, one per set bit of H_RES
    // (y<<9 + y<<7 for 640), so no general multiplier is inferred.
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [COORD_W-1:0] px,
                                                   input logic [COORD_W-1:0] py);
        logic [ADDR_W-1:0] acc;
        acc = ADDR_W'(px);
        for (int i = 0; i < ADDR_W; i++) begin
            if (H_BITS[i]) begin
                acc = acc + (ADDR_W'(py) << i);
            end
        end
        return acc;
    endfunction

    always_comb begin
        adx = '0;
        ady = '0;
        if (x1_q >= x_q) adx = EW'(x1_q - x_q);
        else             adx = EW'(x_q - x1_q);
        if (y1_q >= y_q) ady = EW'(y1_q - y_q);
        else             ady = EW'(y_q - y1_q);
    end

    always_comb begin
        // Both step decisions compare against the same old err.
        e2     = $signed({err_q, 1'b0});
        dx_e   = $signed({dx_q[EW-1], dx_q});
        dy_e   = $signed({dy_q[EW-1], dy_q});
        step_x = (e2 >= dy_e);
        step_y = (e2 <= dx_e);
        err_d  = err_q + (step_x ? dy_q : ZERO_E) + (step_y ? dx_q : ZERO_E);
        x_d    = x_q;
        y_d    = y_q;
        if (step_x) x_d = sx_neg_q ? (x_q - COORD_W'(1)) : (x_q + COORD_W'(1));
        if (step_y) y_d = sy_neg_q ? (y_q - COORD_W'(1)) : (y_q + COORD_W'(1));
        at_end     = (x_q == x1_q) && (y_q == y1_q);
        // Off-screen points still advance the walk but are not written.
        in_range   = ({1'b0, x_q} < H_LIM) && ({1'b0, y_q} < V_LIM);
        pix_addr_d = pix_addr(x_q, y_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            x1_q     <= '0;
            y1_q     <= '0;
            color_q  <= 1'b0;
            dx_q     <= '0;
            dy_q     <= '0;
            err_q    <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
            addr_q   <= '0;
            data_q   <= 1'b0;
            we_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    we_q   <= 1'b0;
                    done_q <= 1'b0;
                    if (cmd_valid && cmd_ready) begin
                        x_q     <= x0;
                        y_q     <= y0;
                        x1_q    <= x1;
                        y1_q    <= y1;
                        color_q <= color;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (!str_line_drawing) begin
                        state_q <= IDLE;
                    end else begin
                        dx_q     <= adx;
                        dy_q     <= -ady;
                        err_q    <= adx - ady;
                        sx_neg_q <= (x1_q < x_q);
                        sy_neg_q <= (y1_q < y_q);
                        state_q  <= PLOT;
                    end
                end
                PLOT: begin
                    if (!str_line_drawing) begin
                        // Abort: no write for this point and no done pulse.
                        we_q    <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        we_q   <= in_range;
                        data_q <= color_q;
                        addr_q <= pix_addr_d;
                        if (at_end) begin
                            state_q <= DONE;
                        end else begin
                            err_q <= err_d;
                            x_q   <= x_d;
                            y_q   <= y_d;
                        end
                    end
                end
                DONE: begin
                    // First DONE cycle shows the last write; done is raised in
                    // the second one so it lands after that write, and IDLE
                    // (cmd_ready) follows one cycle after done.
                    we_q <= 1'b0;
                    if (!done_q) begin
                        done_q <= 1'b1;
                    end else begin
                        done_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready           = (state_q == IDLE) && str_line_drawing && !reset;
    assign busy                = (state_q != IDLE);
    assign done                = done_q;
    assign line_drawing_addr_1 = addr_q;
    assign line_drawing_data   = data_q;
    assign we_line_drawin      = we_q;
    assign dbg_state           = state_q;

endmodule

// File: tb/tb_line_draw_engine.sv
// -----------------------------------------------------------------------------
// tb_line_draw_engine
//
// Table of line commands with their expected pixel writes and plot-cycle
// counts, plus hand-written abort and reset-mid-line sequences. Expected
// {data, addr} words are queued when a command is issued and popped as writes
// appear on the output.
// -----------------------------------------------------------------------------
module tb_line_draw_engine;

    localparam int W = 20;  // {data, addr}

    typedef struct {
        logic [9:0]        x0, y0, x1, y1;
        logic              c;
        int                ncyc;  // plot cycles = max(dx,|dy|)+1
        int                nw;    // writes actually issued (after clipping)
        logic [0:5][18:0]  a;     // expected addresses in order
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        str;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  x0, y0, x1, y1;
    logic        color;
    logic [18:0] addr;
    logic        data, we, busy, done;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] exp_q[$];

    line_draw_engine dut (
        .clk                 (clk),
        .reset               (reset),
        .str_line_drawing    (str),
        .cmd_valid           (cmd_valid),
        .cmd_ready           (cmd_ready),
        .x0                  (x0),
        .y0                  (y0),
        .x1                  (x1),
        .y1                  (y1),
        .color               (color),
        .line_drawing_addr_1 (addr),
        .line_drawing_data   (data),
        .we_line_drawin      (we),
        .busy                (busy),
        .done                (done),
        .dbg_state           (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic observe_write(input string tag);
        logic [W-1:0] e;
        if (we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s_extra_write: got addr %0d, expected no write (t=%0t)", tag, addr, $time);
            end else begin
                e = exp_q.pop_front();
                check({tag, "_write"}, {12'b0, data, addr}, {12'b0, e});
            end
        end
    endtask

    // Waits (bounded) for cmd_ready at a falling edge, then presents the
    // command so it transfers on the next rising edge.
    task automatic issue_cmd(input vec_t v, input string tag, output bit ok);
        int waited = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_ready"}, {31'b0, cmd_ready}, 32'd1);
        ok = (cmd_ready === 1'b1);
        if (!ok) return;
        x0 = v.x0; y0 = v.y0; x1 = v.x1; y1 = v.y1; color = v.c;
        cmd_valid = 1'b1;
        for (int i = 0; i < v.nw; i++) exp_q.push_back({v.c, v.a[i]});
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic run_line(input vec_t v, input string tag);
        bit ok;
        issue_cmd(v, tag, ok);
        if (!ok) return;
        // j counts cycles after the accepting edge: SETUP is j=1, writes
        // appear for j=3..3+ncyc-1, done at j=3+ncyc, ready again after that.
        for (int j = 1; j <= v.ncyc + 5; j++) begin
            @(negedge clk);
            if (j == 3)
                check({tag, "_first_we"}, {31'b0, we}, 32'd1);
            if (j < 3 || j >= 3 + v.ncyc)
                check({tag, "_we_idle"}, {31'b0, we}, 32'd0);
            observe_write(tag);
            check({tag, "_done"}, {31'b0, done}, {31'b0, (j == 3 + v.ncyc)});
            check({tag, "_busy"}, {31'b0, busy}, {31'b0, (j <= 3 + v.ncyc)});
            check({tag, "_cmd_ready"}, {31'b0, cmd_ready}, {31'b0, (j >= 4 + v.ncyc)});
        end
        check({tag, "_drained"}, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        vec_t vecs[6];
        vec_t ab;
        bit   ok;

        reset = 1'b1; str = 1'b1; cmd_valid = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0; color = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_addr", {13'b0, addr}, 32'd0);
        check("rst_data", {31'b0, data}, 32'd0);
        check("rst_we", {31'b0, we}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        reset = 1'b0;

        vecs[0] = '{10'd0, 10'd0, 10'd3, 10'd0, 1'b1, 4, 4,
                    {19'd0, 19'd1, 19'd2, 19'd3, 19'd0, 19'd0}};
        vecs[1] = '{10'd639, 10'd479, 10'd639, 10'd479, 1'b1, 1, 1,
                    {19'd307199, 19'd0, 19'd0, 19'd0, 19'd0, 19'd0}};
        vecs[2] = '{10'd10, 10'd10, 10'd12, 10'd12, 1'b0, 3, 3,
                    {19'd6410, 19'd7051, 19'd7692, 19'd0, 19'd0, 19'd0}};
        vecs[3] = '{10'd5, 10'd4, 10'd4, 10'd0, 1'b1, 5, 5,
                    {19'd2565, 19'd1925, 19'd1284, 19'd644, 19'd4, 19'd0}};
        vecs[4] = '{10'd638, 10'd0, 10'd641, 10'd0, 1'b1, 4, 2,
                    {19'd638, 19'd639, 19'd0, 19'd0, 19'd0, 19'd0}};
        vecs[5] = '{10'd2, 10'd1, 10'd0, 10'd1, 1'b0, 3, 3,
                    {19'd642, 19'd641, 19'd640, 19'd0, 19'd0, 19'd0}};

        for (int i = 0; i < 6; i++) begin
            run_line(vecs[i], $sformatf("vec%0d", i));
        end

        // Window drops right after the second write of a 10-pixel line.
        ab = '{10'd0, 10'd0, 10'd9, 10'd0, 1'b1, 10, 2,
               {19'd0, 19'd1, 19'd0, 19'd0, 19'd0, 19'd0}};
        issue_cmd(ab, "abort", ok);
        if (ok) begin
            for (int j = 1; j <= 4; j++) begin
                @(negedge clk);
                observe_write("abort");
            end
            str = 1'b0;
            for (int j = 5; j <= 16; j++) begin
                @(negedge clk);
                check("abort_we", {31'b0, we}, 32'd0);
                check("abort_done", {31'b0, done}, 32'd0);
                if (j == 5) check("abort_idle", {30'b0, dbg_state}, 32'd0);
                observe_write("abort");
            end
            check("abort_drained", exp_q.size(), 32'd0);
            exp_q.delete();
            str = 1'b1;
            @(negedge clk);
            check("abort_ready_again", {31'b0, cmd_ready}, 32'd1);
        end

        // Reset asserted mid-line.
        issue_cmd(ab, "midrst", ok);
        if (ok) begin
            for (int j = 1; j <= 4; j++) begin
                @(negedge clk);
                observe_write("midrst");
            end
            #1 reset = 1'b1;
            #1;
            check("midrst_addr", {13'b0, addr}, 32'd0);
            check("midrst_data", {31'b0, data}, 32'd0);
            check("midrst_we", {31'b0, we}, 32'd0);
            check("midrst_busy", {31'b0, busy}, 32'd0);
            check("midrst_done", {31'b0, done}, 32'd0);
            check("midrst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
            repeat (3) begin
                @(negedge clk);
                check("midrst_we_held", {31'b0, we}, 32'd0);
            end
            reset = 1'b0;
            check("midrst_drained", exp_q.size(), 32'd0);
            exp_q.delete();
        end

        run_line(vecs[0], "after_rst");
        run_line(vecs[3], "after_rst2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
